// File: rtl/bcrypt_pkg.sv
// Shared bcrypt BRAM map, host-port timing constants and host FSM state type.
// Used by the host port and the loop core.
package bcrypt_pkg;

  localparam int unsigned P_ARRAY    = 32'h0000_0004;
  localparam int unsigned P_S0       = 32'h0000_004C;
  localparam int unsigned P_S1       = 32'h0000_044C;
  localparam int unsigned P_S2       = 32'h0000_084C;
  localparam int unsigned P_S3       = 32'h0000_0C4C;
  localparam int unsigned P_EXP_KEY  = 32'h0000_104C;
  localparam int unsigned P_SALT     = 32'h0000_1094;
  localparam int unsigned COUNT_ADDR = 4260;

  localparam int unsigned P_WORDS    = 18;
  localparam int unsigned S_WORDS    = 1024;
  localparam int unsigned KEY_WORDS  = 18;
  localparam int unsigned SALT_WORDS = 4;
  localparam int unsigned COST_WORDS = 1;

  // One image spans P_ARRAY .. COUNT_ADDR inclusive.
  localparam int unsigned IMG_WORDS = (COUNT_ADDR - P_ARRAY) / 4 + 1;
  localparam int unsigned RD_BASE   = P_ARRAY;
  localparam int unsigned RD_WORDS  = P_WORDS;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned IDLE_GAP  = 2;
  localparam int unsigned CNT_W     = $clog2(IMG_WORDS + 1);

  localparam int unsigned COST_MIN = 4;
  localparam int unsigned COST_MAX = 31;

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StWait, StRead, StHold, StGap, StError
  } host_state_e;

  // The core computes 1 << cost in 32 bits.
  function automatic logic cost_ok(input logic [31:0] cost);
    return (cost >= COST_MIN) && (cost <= COST_MAX);
  endfunction

endpackage

// File: rtl/bcrypt_bram_rd.sv
// Readback path: issues a P-array word address, waits out the BRAM read latency and
// holds the captured word until the sink accepts it.
module bcrypt_bram_rd
  import bcrypt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [CNT_W-1:0] idx,
  input  logic             ack,
  input  logic [31:0]      rd_data,
  output logic [31:0]      addr,
  output logic [31:0]      data,
  output logic             valid,
  output logic             cap
);

  logic [RD_LAT:0] pipe_q;

  assign cap = pipe_q[RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
      addr   <= '0;
      data   <= '0;
      valid  <= 1'b0;
    end else begin
      pipe_q <= {pipe_q[RD_LAT-1:0], issue};
      if (issue) addr <= 32'(RD_BASE) + 32'({idx, 2'b00});
      if (cap) begin
        data  <= rd_data;
        valid <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bcrypt_host_port.sv
// Host side (port B) of the shared bcrypt BRAM: load job image, run core, read back P.
// Optional BCRYPT_COST_CHECK_EN rejects a cost word outside 4..31 before start.
module bcrypt_host_port
  import bcrypt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] start,
  input  logic [31:0] done,
  output logic        busy,
  output logic        err,
  output logic        BRAM_Rst_B,
  output logic        BRAM_Clk_B,
  output logic        BRAM_En_B,
  output logic [3:0]  BRAM_WE_B,
  output logic [31:0] BRAM_Addr_B,
  output logic [31:0] BRAM_WrData_B,
  input  logic [31:0] BRAM_RdData_B
);

  host_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s_ready_q, start_q;
  logic [3:0]       we_q;
  logic [31:0]      wr_addr_q, wr_data_q, rd_addr;
  logic             s_hs, last_k, rd_ack, rd_cap, rd_issue;
  logic [CNT_W-1:0] rd_idx;

  assign s_hs   = s_valid & s_ready_q;
  assign last_k = (cnt_q == CNT_W'(IMG_WORDS - 1));
  assign rd_ack = m_valid & m_ready;

  always_comb begin
    rd_issue = 1'b0;
    rd_idx   = '0;
    if (state_q == StWait && done != '0) begin
      rd_issue = 1'b1;
    end else if (state_q == StHold && rd_ack && cnt_q != CNT_W'(RD_WORDS - 1)) begin
      rd_issue = 1'b1;
      rd_idx   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      we_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      we_q <= '0;
      unique case (state_q)
        StIdle, StLoad: begin
          s_ready_q <= 1'b1;
          if (s_hs) begin
            we_q      <= 4'hF;
            wr_addr_q <= 32'(P_ARRAY) + 32'({cnt_q, 2'b00});
            wr_data_q <= s_data;
            cnt_q     <= cnt_q + 1'b1;
            state_q   <= StLoad;
            if (s_last != last_k) begin
              state_q   <= StError;
              s_ready_q <= 1'b0;
            end else if (last_k) begin
              s_ready_q <= 1'b0;
`ifdef BCRYPT_COST_CHECK_EN
              state_q   <= cost_ok(s_data) ? StStart : StError;
`else
              state_q   <= StStart;
`endif
            end
          end
        end
        StStart: begin
          start_q <= 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          if (done != '0) begin
            cnt_q   <= '0;
            state_q <= StRead;
          end
        end
        StRead: begin
          if (rd_cap) state_q <= StHold;
        end
        StHold: begin
          if (rd_ack) begin
            if (cnt_q == CNT_W'(RD_WORDS - 1)) begin
              cnt_q   <= '0;
              start_q <= 1'b0;
              state_q <= StGap;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= StRead;
            end
          end
        end
        StGap: begin
          if (cnt_q == CNT_W'(IDLE_GAP - 1)) begin
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StError: begin
          s_ready_q <= 1'b0;
          start_q   <= 1'b0;
        end
      endcase
    end
  end

  bcrypt_bram_rd u_rd (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (rd_issue),
    .idx     (rd_idx),
    .ack     (rd_ack),
    .rd_data (BRAM_RdData_B),
    .addr    (rd_addr),
    .data    (m_data),
    .valid   (m_valid),
    .cap     (rd_cap)
  );

  assign s_ready       = s_ready_q;
  assign start         = {31'b0, start_q};
  assign busy          = (state_q != StIdle);
  assign err           = (state_q == StError);
  assign BRAM_Rst_B    = 1'b0;
  assign BRAM_Clk_B    = clk;
  assign BRAM_En_B     = 1'b1;
  assign BRAM_WE_B     = we_q;
  assign BRAM_Addr_B   = (state_q == StRead || state_q == StHold) ? rd_addr : wr_addr_q;
  assign BRAM_WrData_B = wr_data_q;

endmodule

// File: tb/tb_bcrypt_host_port.sv
// Randomized bench for bcrypt_host_port with a BRAM model, a loop-core stub and
// a queue-level reference of the image and readback contents.
module tb_bcrypt_host_port;

  localparam int NW  = 1065;
  localparam int RDW = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready = 1'b0;
  logic [31:0] start, done = '0;
  logic        busy, err;
  logic        BRAM_Rst_B, BRAM_Clk_B, BRAM_En_B;
  logic [3:0]  BRAM_WE_B;
  logic [31:0] BRAM_Addr_B, BRAM_WrData_B, BRAM_RdData_B;

  always #5 clk = ~clk;

  bcrypt_host_port dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .start         (start),
    .done          (done),
    .busy          (busy),
    .err           (err),
    .BRAM_Rst_B    (BRAM_Rst_B),
    .BRAM_Clk_B    (BRAM_Clk_B),
    .BRAM_En_B     (BRAM_En_B),
    .BRAM_WE_B     (BRAM_WE_B),
    .BRAM_Addr_B   (BRAM_Addr_B),
    .BRAM_WrData_B (BRAM_WrData_B),
    .BRAM_RdData_B (BRAM_RdData_B)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Word-indexed BRAM (index = byte address / 4), 2-cycle read latency, plus core stub:
  // a few cycles after start it fills P[i] = 0x100 + i and raises done; start=0 clears it.
  logic [31:0] mem [0:NW];
  logic [31:0] rd_p0, rd_p1;
  int          core_cnt = 0;
  int          a;

  assign BRAM_RdData_B = rd_p1;

  always @(posedge clk) begin
    a = int'(BRAM_Addr_B >> 2);
    rd_p0 <= (a <= NW) ? mem[a] : 32'hDEAD_BEEF;
    rd_p1 <= rd_p0;
    if (BRAM_WE_B == 4'hF && a <= NW) mem[a] <= BRAM_WrData_B;
    if (start == 32'd0) begin
      done     <= '0;
      core_cnt <= 0;
    end else if (done == '0) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt == 6) begin
        for (int i = 0; i < RDW; i++) mem[1 + i] <= 32'h100 + i;
        done <= 32'hFF;
      end
    end
  end

  logic [31:0] img [0:NW-1];

  task automatic send_image(input int n_words, input int last_at, input logic [31:0] cost);
    for (int k = 0; k < n_words; k++) begin
      int t = 0;
      logic [31:0] d;
      d = (k == NW - 1) ? cost : $urandom;
      img[k] = d;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (k == last_at);
      while (!s_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_eq("s_ready_timeout", 32'd0, 32'd1);
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic read_back(input bit bp);
    for (int j = 0; j < RDW; j++) begin
      int t = 0;
      int stall;
      logic [31:0] exp;
      exp = 32'h100 + j;
      while (!m_valid && t < 200) begin
        m_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        t++;
      end
      if (!m_valid) begin
        m_ready = 1'b0;
        check_eq("rd_timeout", 32'd0, 32'd1);
        return;
      end
      if (j > 0) check_eq("rd_lat", t, 32'd3);
      check_eq($sformatf("m_data[%0d]", j), m_data, exp);
      stall = (bp && j == 3) ? 7 : $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        m_ready = 1'b0;
        @(negedge clk);
        if (bp && j == 3) begin
          check_eq("bp_valid", {31'b0, m_valid}, 32'd1);
          check_eq("bp_data", m_data, exp);
        end
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    check_eq("start_clr", start, 32'd0);
    check_eq("gap_busy0", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check_eq("gap_busy1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check_eq("idle_busy", {31'b0, busy}, 32'd0);
    check_eq("idle_ready", {31'b0, s_ready}, 32'd1);
  endtask

  task automatic run_happy(input logic [31:0] cost, input bit bp);
    int diffs = 0;
    send_image(NW, NW - 1, cost);
    check_eq("start_lat1", start, 32'd0);
    @(negedge clk);
    check_eq("start_lat2", start, 32'd1);
    for (int k = 0; k < NW; k++) if (mem[k + 1] !== img[k]) diffs++;
    check_eq("image", diffs, 32'd0);
    read_back(bp);
  endtask

  task automatic expect_error(input string tag);
    int starts = 0;
    int writes = 0;
    check_eq({tag, "_err"}, {31'b0, err}, 32'd1);
    check_eq({tag, "_ready"}, {31'b0, s_ready}, 32'd0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = $urandom;
    repeat (10) begin
      @(negedge clk);
      if (start != '0) starts++;
      if (BRAM_WE_B != '0) writes++;
    end
    s_valid = 1'b0;
    check_eq({tag, "_nostart"}, starts, 32'd0);
    check_eq({tag, "_noconsume"}, writes, 32'd0);
    check_eq({tag, "_err_hold"}, {31'b0, err}, 32'd1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check_eq("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check_eq("rst_m_data", m_data, 32'd0);
    check_eq("rst_start", start, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_en", {31'b0, BRAM_En_B}, 32'd1);
    check_eq("rst_bram_rst", {31'b0, BRAM_Rst_B}, 32'd0);
    check_eq("rst_we", {28'b0, BRAM_WE_B}, 32'd0);
    check_eq("rst_addr", BRAM_Addr_B, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_s_ready", {31'b0, s_ready}, 32'd1);

    run_happy(32'd5, 1'b1);
    run_happy(32'd5, 1'b0);

    send_image(1000, 999, 32'd5);
    expect_error("early_last");
    do_reset();

    send_image(NW, -1, 32'd5);
    expect_error("missing_last");
    do_reset();

`ifdef BCRYPT_COST_CHECK_EN
    send_image(NW, NW - 1, 32'd3);
    expect_error("cost3");
    do_reset();
    send_image(NW, NW - 1, 32'd32);
    expect_error("cost32");
    do_reset();
`else
    run_happy(32'd32, 1'b0);
`endif

    send_image(NW, NW - 1, 32'd5);
    @(negedge clk);
    check_eq("wait_start", start, 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_start", start, 32'd0);
    check_eq("async_rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_happy(32'd5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
